// File: rtl/gardner_ted_gen.sv
// gardner_ted_gen: pipelined Gardner timing-error detector for the MSK
// timing-recovery loop. The detector computes a full or sign-reduced error
// from I/Q samples, optionally block-averages it, and saturates it to WO
// bits. It also provides I/Q raw samples delayed by RAW_DLY for the
// interpolator.
// Optional build macro GTED_ROUND_EN: the macro selects round-half-up in
// place of truncation for the SHIFT shift and the averaging shift.
module gardner_ted_gen #(
  parameter int OSF      = 20,
  parameter int WI       = 16,
  parameter int WO       = 18,
  parameter int SHIFT    = 16,
  parameter int AVG_LOG2 = 0,
  parameter int RAW_DLY  = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [WI-1:0] i_in,
  input  logic signed [WI-1:0] q_in,
  input  logic                 iq_val,
  input  logic                 sym_valid_i,
  input  logic                 mode_i,
  output logic signed [WO-1:0] e_out_o,
  output logic                 e_valid_o,
  output logic                 sat_o,
  output logic signed [WI-1:0] i_raw_delay_o,
  output logic signed [WI-1:0] q_raw_delay_o
);

  localparam int DEPTH = (OSF > RAW_DLY) ? OSF : RAW_DLY;
  localparam int HALF  = OSF / 2;
  localparam int DW    = WI + 1;
  localparam int PW    = 2 * WI + 2;
  localparam int AW    = PW + AVG_LOG2;
  localparam int CW    = $clog2(OSF + 1);
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-WO+1){1'b1}}, {(WO-1){1'b0}}};

  typedef enum logic {FILL, RUN} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     fill_cnt, fill_cnt_next;
  logic signed [WI-1:0] i_dly [DEPTH];
  logic signed [WI-1:0] q_dly [DEPTH];
  logic signed [WI-1:0] tap_i, tap_q;
  logic              fill_done, trigger;

  logic signed [WI-1:0] h_i, h_q;
  logic signed [DW-1:0] d_i, d_q;
  logic                 m1, v1;
  logic signed [PW-1:0] p_i, p_q;
  logic                 v2;
  logic signed [PW-1:0] sum_c;
  logic signed [PW-1:0] e3;
  logic                 v3;
  logic signed [AW-1:0] blk_val;
  logic                 blk_done;

  // Per-rail product: full Gardner uses Ih*dI, sign Gardner scales Ih by sgn(dI)*2^WI
  function automatic logic signed [PW-1:0] rail_prod(input logic signed [WI-1:0] h,
                                                     input logic signed [DW-1:0] d,
                                                     input logic m);
    logic signed [PW-1:0] hx;
    hx = PW'(h);
    if (!m) return hx * PW'(d);
    else if (d > 0) return hx <<< WI;
    else if (d < 0) return -(hx <<< WI);
    else return '0;
  endfunction

  // Sample delay lines for both rails; they shift only on qualified samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        i_dly[k] <= '0;
        q_dly[k] <= '0;
      end
    end else if (iq_val) begin
      i_dly[0] <= i_in;
      q_dly[0] <= q_in;
      for (int k = 1; k < DEPTH; k++) begin
        i_dly[k] <= i_dly[k-1];
        q_dly[k] <= q_dly[k-1];
      end
    end
  end

  // Fill state register and sample counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
    end
  end

  // Leave FILL once OSF samples have entered; the completing sample may itself trigger
  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    fill_done     = 1'b0;
    if (state == FILL && iq_val) begin
      fill_cnt_next = fill_cnt + 1'b1;
      if (fill_cnt == CW'(OSF - 1)) begin
        fill_done  = 1'b1;
        state_next = RUN;
      end
    end
  end

  assign trigger = iq_val && sym_valid_i && ((state == RUN) || fill_done);

  // S1: capture half-symbol tap and full-symbol difference at WI+1 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_i <= '0; h_q <= '0; d_i <= '0; d_q <= '0; m1 <= 1'b0; v1 <= 1'b0;
    end else begin
      v1  <= trigger;
      m1  <= mode_i;
      h_i <= i_dly[HALF-1];
      h_q <= q_dly[HALF-1];
      d_i <= $signed({i_in[WI-1], i_in}) - $signed({i_dly[OSF-1][WI-1], i_dly[OSF-1]});
      d_q <= $signed({q_in[WI-1], q_in}) - $signed({q_dly[OSF-1][WI-1], q_dly[OSF-1]});
    end
  end

  // S2: per-rail products
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_i <= '0; p_q <= '0; v2 <= 1'b0;
    end else begin
      v2  <= v1;
      p_i <= rail_prod(h_i, d_i, m1);
      p_q <= rail_prod(h_q, d_q, m1);
    end
  end

  assign sum_c = p_i + p_q;

`ifdef GTED_ROUND_EN
  localparam logic [PW-1:0] RND_S = ({{(PW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
  // S3: rounded arithmetic shift of the rail sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e3 <= '0; v3 <= 1'b0;
    end else begin
      v3 <= v2;
      e3 <= (sum_c + $signed(RND_S)) >>> SHIFT;
    end
  end
`else
  // S3: truncating arithmetic shift of the rail sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e3 <= '0; v3 <= 1'b0;
    end else begin
      v3 <= v2;
      e3 <= sum_c >>> SHIFT;
    end
  end
`endif

  generate
    if (AVG_LOG2 == 0) begin : g_noavg
      assign blk_done = v3;
      assign blk_val  = AW'(e3);
    end else begin : g_avg
      logic signed [AW-1:0]   acc;
      logic signed [AW-1:0]   acc_sum;
      logic [AVG_LOG2-1:0]    cnt;
      assign acc_sum  = acc + AW'(e3);
      assign blk_done = v3 && (&cnt);
`ifdef GTED_ROUND_EN
      localparam logic [AW-1:0] RND_A = {{(AW-1){1'b0}}, 1'b1} << (AVG_LOG2 - 1);
      assign blk_val = (acc_sum + $signed(RND_A)) >>> AVG_LOG2;
`else
      assign blk_val = acc_sum >>> AVG_LOG2;
`endif
      // Block accumulator; clears in the same cycle the block result is taken
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          acc <= '0; cnt <= '0;
        end else if (v3) begin
          if (&cnt) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  // S4: saturate to WO bits and present a one-cycle valid; value holds between pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_out_o <= '0; e_valid_o <= 1'b0; sat_o <= 1'b0;
    end else begin
      e_valid_o <= blk_done;
      sat_o     <= 1'b0;
      if (blk_done) begin
        if (blk_val > SAT_HI) begin
          e_out_o <= SAT_HI[WO-1:0];
          sat_o   <= 1'b1;
        end else if (blk_val < SAT_LO) begin
          e_out_o <= SAT_LO[WO-1:0];
          sat_o   <= 1'b1;
        end else begin
          e_out_o <= blk_val[WO-1:0];
        end
      end
    end
  end

  generate
    if (RAW_DLY == 1) begin : g_raw1
      assign tap_i = i_in;
      assign tap_q = q_in;
    end else begin : g_rawn
      assign tap_i = i_dly[RAW_DLY-2];
      assign tap_q = q_dly[RAW_DLY-2];
    end
  endgenerate

  // Raw delayed I/Q; the output register itself is the last delay stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_raw_delay_o <= '0;
      q_raw_delay_o <= '0;
    end else if (iq_val) begin
      i_raw_delay_o <= tap_i;
      q_raw_delay_o <= tap_q;
    end
  end

endmodule

// File: tb/tb_gardner_ted_gen.sv
// tb_gardner_ted_gen: scoreboard bench for gardner_ted_gen. One instance uses
// default parameters, a second uses WO=12 and AVG_LOG2=2 on the same inputs.
module tb_gardner_ted_gen;

  localparam int OSF   = 20;
  localparam int WI    = 16;
  localparam int SHIFT = 16;
  localparam int RAW   = 20;
  localparam int WO_A  = 18;
  localparam int WO_B  = 12;
  localparam int AVG_B = 2;

  typedef struct {
    longint val;
    bit     sat;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic signed [WI-1:0] i_in, q_in;
  logic iq_val, sym_valid_i, mode_i;
  logic signed [WO_A-1:0] e_out_a;
  logic e_valid_a, sat_a;
  logic signed [WI-1:0] i_raw_a, q_raw_a;
  logic signed [WO_B-1:0] e_out_b;
  logic e_valid_b, sat_b;
  logic signed [WI-1:0] i_raw_b, q_raw_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit directed = 1'b0;
  int hi[$];
  int hq[$];
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  longint acc_b = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  gardner_ted_gen #(.OSF(OSF), .WI(WI), .WO(WO_A), .SHIFT(SHIFT), .AVG_LOG2(0), .RAW_DLY(RAW)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_in(i_in), .q_in(q_in), .iq_val(iq_val),
    .sym_valid_i(sym_valid_i), .mode_i(mode_i), .e_out_o(e_out_a), .e_valid_o(e_valid_a),
    .sat_o(sat_a), .i_raw_delay_o(i_raw_a), .q_raw_delay_o(q_raw_a));

  gardner_ted_gen #(.OSF(OSF), .WI(WI), .WO(WO_B), .SHIFT(SHIFT), .AVG_LOG2(AVG_B), .RAW_DLY(RAW)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_in(i_in), .q_in(q_in), .iq_val(iq_val),
    .sym_valid_i(sym_valid_i), .mode_i(mode_i), .e_out_o(e_out_b), .e_valid_o(e_valid_b),
    .sat_o(sat_b), .i_raw_delay_o(i_raw_b), .q_raw_delay_o(q_raw_b));

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample taken 'back' samples before the newest one; zero before history starts
  function automatic longint tap(input bit q_rail, input int back);
    int idx;
    idx = (q_rail ? hq.size() : hi.size()) - 1 - back;
    if (idx < 0) return 0;
    return q_rail ? longint'(hq[idx]) : longint'(hi[idx]);
  endfunction

  function automatic longint rail(input longint c, input longint h, input longint p, input bit m);
    longint d;
    d = c - p;
    if (!m) return h * d;
    if (d > 0) return h * (longint'(1) << WI);
    if (d < 0) return -h * (longint'(1) << WI);
    return 0;
  endfunction

  function automatic longint ref_err(input bit m);
    longint s;
    s = rail(tap(0, 0), tap(0, OSF/2), tap(0, OSF), m) + rail(tap(1, 0), tap(1, OSF/2), tap(1, OSF), m);
`ifdef GTED_ROUND_EN
    s = s + (longint'(1) << (SHIFT - 1));
`endif
    return s >>> SHIFT;
  endfunction

  function automatic longint clipv(input longint v, input int wo, output bit s);
    longint hi_lim, lo_lim;
    hi_lim = (longint'(1) << (wo - 1)) - 1;
    lo_lim = -(longint'(1) << (wo - 1));
    s = 1'b1;
    if (v > hi_lim) return hi_lim;
    if (v < lo_lim) return lo_lim;
    s = 1'b0;
    return v;
  endfunction

  task automatic pushA(input longint v, input bit s, input int due);
    exp_t e;
    e.val = v; e.sat = s; e.due = due;
    q_a.push_back(e);
  endtask

  task automatic pushB(input longint v, input bit s, input int due);
    exp_t e;
    e.val = v; e.sat = s; e.due = due;
    q_b.push_back(e);
  endtask

  // One cycle of stimulus; raw-delay outputs are checked against all samples entered so far
  task automatic applyStimulus(input bit v, input bit sv, input bit m, input int i, input int q);
    longint e, avg, cv;
    bit s;
    @(posedge clk);
    #1;
    checkOutput("raw_i", i_raw_a, (hi.size() >= RAW) ? hi[hi.size()-RAW] : 0);
    checkOutput("raw_q", q_raw_a, (hq.size() >= RAW) ? hq[hq.size()-RAW] : 0);
    iq_val = v; sym_valid_i = sv; mode_i = m;
    i_in = WI'(i); q_in = WI'(q);
    last_cyc = cyc;
    if (v) begin
      hi.push_back(i);
      hq.push_back(q);
      if (sv && hi.size() >= OSF && !directed) begin
        e = ref_err(m);
        cv = clipv(e, WO_A, s);
        pushA(cv, s, cyc + 4);
        acc_b += e;
        cnt_b++;
        if (cnt_b == (1 << AVG_B)) begin
`ifdef GTED_ROUND_EN
          avg = (acc_b + (longint'(1) << (AVG_B - 1))) >>> AVG_B;
`else
          avg = acc_b >>> AVG_B;
`endif
          cv = clipv(avg, WO_B, s);
          pushB(cv, s, cyc + 4);
          acc_b = 0;
          cnt_b = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic randomSample(input int strobe_pct);
    int ri, rq;
    bit v, sv, m;
    v  = ($urandom_range(99) < 75);
    sv = ($urandom_range(99) < strobe_pct);
    m  = $urandom_range(1) == 1;
    ri = int'($urandom_range(65535)) - 32768;
    rq = int'($urandom_range(65535)) - 32768;
    applyStimulus(v, sv, m, ri, rq);
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge
  task automatic doReset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    iq_val = 1'b0; sym_valid_i = 1'b0;
    hi.delete(); hq.delete(); q_a.delete(); q_b.delete();
    acc_b = 0; cnt_b = 0;
    #2;
    checkOutput("rst_e_out_a", e_out_a, 0);
    checkOutput("rst_e_valid_a", e_valid_a, 0);
    checkOutput("rst_sat_a", sat_a, 0);
    checkOutput("rst_raw_i", i_raw_a, 0);
    checkOutput("rst_raw_q", q_raw_a, 0);
    checkOutput("rst_e_out_b", e_out_b, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: pops an expectation on every valid pulse
  always @(negedge clk) begin
    if (reset_n) begin
      if (e_valid_a) begin
        if (q_a.size() == 0) checkOutput("unexpected_valid_a", 1, 0);
        else begin
          ea = q_a.pop_front();
          checkOutput("e_out_a", e_out_a, ea.val);
          checkOutput("sat_a", sat_a, ea.sat);
          checkOutput("latency_a", cyc, ea.due);
        end
      end else begin
        checkOutput("sat_idle_a", sat_a, 0);
      end
      if (e_valid_b) begin
        if (q_b.size() == 0) checkOutput("unexpected_valid_b", 1, 0);
        else begin
          eb = q_b.pop_front();
          checkOutput("e_out_b", e_out_b, eb.val);
          checkOutput("sat_b", sat_b, eb.sat);
          checkOutput("latency_b", cyc, eb.due);
        end
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int x;
    reset_n = 1'b0;
    iq_val = 1'b0; sym_valid_i = 1'b0; mode_i = 1'b0;
    i_in = '0; q_in = '0;
    #12;
    checkOutput("init_e_valid_a", e_valid_a, 0);
    checkOutput("init_e_out_a", e_out_a, 0);
    #5;
    reset_n = 1'b1;

    // Directed ramp, full and sign mode, then constant input in sign mode
    directed = 1'b1;
    for (int pass = 0; pass < 3; pass++) begin
      doReset();
      for (int n = 0; n <= 30; n++) begin
        applyStimulus(1'b1, n == 30, pass != 0, (pass == 2) ? 500 : 100 * n, 0);
        if (n == 30) pushA((pass == 0) ? 61 : (pass == 1) ? 2000 : 0, 1'b0, last_cyc + 4);
      end
      idle(6);
    end

    // Saturation, positive then negative, four triggers per run
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      for (int n = 0; n <= 23; n++) begin
        if (pass == 0) x = (n < 10) ? -32768 : 32767;
        else x = (n < 20) ? -32768 : 32767;
        applyStimulus(1'b1, n >= 20, 1'b0, x, x);
        if (n >= 20) pushA((pass == 0) ? 65533 : -65535, 1'b0, last_cyc + 4);
        if (n == 23) pushB((pass == 0) ? 2047 : -2048, 1'b1, last_cyc + 4);
      end
      idle(6);
    end

    // Averaging block 10,20,30,40 in sign mode on the I rail
    doReset();
    for (int n = 0; n <= 23; n++) begin
      if (n >= 10 && n <= 13) x = 10 * (n - 9);
      else if (n >= 20) x = 1000;
      else x = 0;
      applyStimulus(1'b1, n >= 20, 1'b1, x, 0);
      if (n >= 20) pushA(10 * (n - 19), 1'b0, last_cyc + 4);
      if (n == 23) pushB(25, 1'b0, last_cyc + 4);
    end
    idle(6);
    directed = 1'b0;

    // Fill: strobe on every sample, first result only from the OSF-th sample
    doReset();
    for (int n = 0; n < OSF + 2; n++) applyStimulus(1'b1, 1'b1, 1'b0,
        int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    idle(6);

    for (int k = 0; k < 800; k++) randomSample(30);
    for (int k = 0; k < 200; k++) randomSample(95);

    // Reset two clocks after a trigger: in-flight results must vanish
    applyStimulus(1'b1, 1'b1, 1'b0, 12345, -23456);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    doReset();
    for (int n = 0; n < OSF - 1; n++) applyStimulus(1'b1, 1'b1, 1'b0,
        int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    idle(6);
    for (int k = 0; k < 300; k++) randomSample(40);

    idle(10);
    checkOutput("drain_a", q_a.size(), 0);
    checkOutput("drain_b", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
